// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// Optional feature macro used by the top: MULT_EARLY_EXIT_EN.
package mult_pkg;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;

    // Largest magnitudes that still fit a signed 32-bit result.
    localparam logic [WIDTH-1:0] MAG_MAX_POS = 32'h7FFFFFFF;
    localparam logic [WIDTH-1:0] MAG_MAX_NEG = 32'h80000000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // True when shifting mag left by idx pushes a set bit past the MSB.
    function automatic logic lostBits(input logic [WIDTH-1:0] mag,
                                      input logic [IDX_W-1:0] idx);
        return |(mag & ~({WIDTH{1'b1}} >> idx));
    endfunction

endpackage

// File: rtl/shift_add_mult_twos_negate.sv
// Combinational two's-complement negate; -(0x80000000) yields 0x80000000.
module twos_negate
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] negated
);

    assign negated = ~value + WIDTH'(1);

endmodule

// File: rtl/shift_add_mult.sv
// Iterative 32-bit signed shift-add multiplier driving an external barrel
// left shifter. One multiplier bit is examined per cycle.
// Optional feature: define MULT_EARLY_EXIT_EN to finish as soon as no set
// multiplier bits remain at or above the current index.
//
// Handshake: ctrl_MULT is a single-cycle start strobe that is always
// accepted (it restarts any operation in flight, discarding its result);
// data_resultRDY is a one-cycle pulse during which data_result and
// data_exception are valid. There is no back-pressure.
module shift_add_mult
    import mult_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] shift_dataA,
    output logic [IDX_W-1:0] shift_shiftAm,
    input  logic [WIDTH-1:0] shift_out,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [1:0]       dbgState
);

    state_t           state;
    logic [WIDTH-1:0] magB;
    logic [WIDTH-1:0] acc;
    logic             neg;
    logic             ovf;

    logic [WIDTH-1:0] negA;
    logic [WIDTH-1:0] negB;
    logic [WIDTH-1:0] negAcc;
    logic [WIDTH-1:0] magANext;
    logic [WIDTH-1:0] magBNext;
    logic [WIDTH:0]   sum;
    logic             excCond;
    logic             earlyDone;
    logic             finish;

    twos_negate uNegA   (.value(data_operandA), .negated(negA));
    twos_negate uNegB   (.value(data_operandB), .negated(negB));
    twos_negate uNegAcc (.value(acc),           .negated(negAcc));

    assign magANext = data_operandA[WIDTH-1] ? negA : data_operandA;
    assign magBNext = data_operandB[WIDTH-1] ? negB : data_operandB;

    // Extra top bit captures the carry out of the partial-product add.
    assign sum = {1'b0, acc} + {1'b0, shift_out};

    // The negative side can reach one more magnitude than the positive side.
    assign excCond = ovf
                   | (!neg && (acc > MAG_MAX_POS))
                   | ( neg && (acc > MAG_MAX_NEG));

`ifdef MULT_EARLY_EXIT_EN
    assign earlyDone = (state == RUN) && ((magB >> shift_shiftAm) == '0);
`else
    assign earlyDone = 1'b0;
`endif

    // A restart in RUN discards the in-flight result; one in DONE does not.
    assign finish = (state == DONE) || (earlyDone && !ctrl_MULT);

    assign dbgState = state;

    // FSM, accumulator and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            magB           <= '0;
            acc            <= '0;
            neg            <= 1'b0;
            ovf            <= 1'b0;
            shift_dataA    <= '0;
            shift_shiftAm  <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (finish) begin
                data_result    <= excCond ? '0 : (neg ? negAcc : acc);
                data_exception <= excCond;
                data_resultRDY <= 1'b1;
            end
            if (ctrl_MULT) begin
                state         <= RUN;
                busy          <= 1'b1;
                shift_dataA   <= magANext;
                magB          <= magBNext;
                neg           <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                acc           <= '0;
                ovf           <= 1'b0;
                shift_shiftAm <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    RUN: begin
                        if (earlyDone) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            if (magB[shift_shiftAm]) begin
                                acc <= sum[WIDTH-1:0];
                                if (sum[WIDTH] || lostBits(shift_dataA, shift_shiftAm))
                                    ovf <= 1'b1;
                            end
                            shift_shiftAm <= shift_shiftAm + IDX_W'(1);
                            if (shift_shiftAm == IDX_W'(WIDTH - 1))
                                state <= DONE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed testbench for shift_add_mult with a behavioural barrel shifter.
module tb_shift_add_mult;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] shift_dataA;
    logic [4:0]  shift_shiftAm;
    logic [31:0] shift_out;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [1:0]  dbgState;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        string       name;
    } vec_t;
    vec_t vecs[$];

    shift_add_mult dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .shift_dataA    (shift_dataA),
        .shift_shiftAm  (shift_shiftAm),
        .shift_out      (shift_out),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .dbgState       (dbgState)
    );

    // Clock and the external barrel left shifter.
    always #5 clock = ~clock;
    assign shift_out = shift_dataA << shift_shiftAm;

    function automatic logic [31:0] absv(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    // Cycles from the start edge to the edge after which RDY is high.
    function automatic int expLat(input logic [31:0] b);
        logic [31:0] m;
        m = absv(b);
`ifdef MULT_EARLY_EXIT_EN
        for (int i = 31; i >= 0; i--)
            if (m[i]) return 2 + i;
        return 1;
`else
        if (m == 32'd0) return 33;
        return 33;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic addVec(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc, input string name);
        vec_t v;
        v.a = a; v.b = b; v.res = res; v.exc = exc; v.name = name;
        vecs.push_back(v);
    endtask

    // Start pulse spanning one rising edge; operands scrambled afterwards.
    task automatic startMult(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic waitRdy(input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic scoreRdy(input string name);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({name, "_result"}, {32'd0, data_result}, {32'd0, e[31:0]});
            check({name, "_exception"}, {63'd0, data_exception}, {63'd0, e[32]});
        end
    endtask

    task automatic countRdy(input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) cnt++;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        int rstAt;
        int restartAt;
        logic found;
        logic [31:0] held;

        reset_n = 1'b0;
        ctrl_MULT = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        check("reset_outputs", {25'd0, data_result, data_exception, data_resultRDY, busy, shift_dataA[0], shift_shiftAm},
              64'd0);
        check("reset_shifter", {27'd0, shift_dataA, shift_shiftAm}, 64'd0);
        check("reset_state", {62'd0, dbgState}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        addVec(32'd7,          32'd6,          32'd42,         1'b0, "7x6");
        addVec(-32'sd3,        32'd5,          32'hFFFFFFF1,   1'b0, "m3x5");
        addVec(32'h80000000,   32'd1,          32'h80000000,   1'b0, "minx1");
        addVec(32'h00010000,   32'h00010000,   32'd0,          1'b1, "lostbits");
        addVec(32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b1, "minxm1");
        addVec(32'd9,          32'd3,          32'd27,         1'b0, "9x3");
        addVec(32'd0,          32'd8,          32'd0,          1'b0, "0x8");
        addVec(32'd8,          32'd0,          32'd0,          1'b0, "8x0");
        addVec(-32'sd7,        -32'sd6,        32'd42,         1'b0, "m7xm6");
        addVec(32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   1'b0, "maxx1");
        addVec(32'h7FFFFFFF,   32'd2,          32'd0,          1'b1, "maxx2");
        addVec(32'h40000000,   -32'sd2,        32'h80000000,   1'b0, "negedge_ok");
        addVec(32'h40000000,   32'd2,          32'd0,          1'b1, "posedge_ovf");
        addVec(32'h0000FFFF,   32'h0000FFFF,   32'd0,          1'b1, "ffffsq");
        addVec(32'h00010000,   -32'sd32768,    32'h80000000,   1'b0, "neg_min");
        addVec(32'h60000000,   32'd3,          32'd0,          1'b1, "carryout");
        addVec(-32'sd1000,     32'd1000,       32'hFFF0BDC0,   1'b0, "m1000x1000");

        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].exc, vecs[i].res});
            startMult(vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_busy"}, {63'd0, busy}, 64'd1);
            check({vecs[i].name, "_dataA"}, {32'd0, shift_dataA}, {32'd0, absv(vecs[i].a)});
            check({vecs[i].name, "_idx0"}, {59'd0, shift_shiftAm}, 64'd0);
            waitRdy(100, lat);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(expLat(vecs[i].b)));
            scoreRdy(vecs[i].name);
            check({vecs[i].name, "_idle_at_rdy"}, {63'd0, busy}, 64'd0);
            held = data_result;
            @(posedge clock);
            #1;
            check({vecs[i].name, "_rdy_one_cycle"}, {63'd0, data_resultRDY}, 64'd0);
            check({vecs[i].name, "_held"}, {32'd0, data_result}, {32'd0, vecs[i].res});
            check({vecs[i].name, "_held_same"}, {32'd0, data_result}, {32'd0, held});
        end

        // Asynchronous reset in the middle of 123 x 456.
`ifdef MULT_EARLY_EXIT_EN
        rstAt = 5;
`else
        rstAt = 10;
`endif
        startMult(32'd123, 32'd456);
        repeat (rstAt) @(posedge clock);
        #3;
        check("midrst_running", {62'd0, dbgState}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_outputs", {30'd0, data_result, data_exception, data_resultRDY, busy, 1'b0}, 64'd0);
        check("midrst_shifter", {27'd0, shift_dataA, shift_shiftAm}, 64'd0);
        check("midrst_state", {62'd0, dbgState}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("postrst_idle", {62'd0, dbgState}, 64'd0);
        countRdy(40, cnt);
        check("postrst_no_rdy", 64'(cnt), 64'd0);

        // Restart while 2 x 3 is still running.
`ifdef MULT_EARLY_EXIT_EN
        restartAt = 1;
`else
        restartAt = 5;
`endif
        exp_q.push_back({1'b0, 32'd20});
        startMult(32'd2, 32'd3);
        countRdy(restartAt, cnt);
        check("restart_no_early_rdy", 64'(cnt), 64'd0);
        startMult(32'd4, 32'd5);
        waitRdy(100, lat);
        check("restart_latency", 64'(lat), 64'(expLat(32'd5)));
        scoreRdy("restart");
        countRdy(40, cnt);
        check("restart_single_rdy", 64'(cnt), 64'd0);

        // Restart on the DONE cycle: old result still pulses, new one follows.
        exp_q.push_back({1'b0, 32'h80000000});
        exp_q.push_back({1'b0, 32'd12});
        startMult(32'd1, 32'h80000000);
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clock);
            #1;
            if (dbgState == 2'b10) begin
                found = 1'b1;
                break;
            end
        end
        check("done_reached", {63'd0, found}, 64'd1);
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        ctrl_MULT = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        check("done_restart_rdy", {63'd0, data_resultRDY}, 64'd1);
        scoreRdy("done_old");
        check("done_restart_busy", {63'd0, busy}, 64'd1);
        check("done_restart_state", {62'd0, dbgState}, 64'd1);
        waitRdy(100, lat);
        check("done_new_latency", 64'(lat), 64'(expLat(32'd4)));
        scoreRdy("done_new");

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
